ctrl_pipe: RTL and testbench

- Carries the decoded control bundle from the decode stage through the EX, MEM and WB pipeline registers.
- Detects load-use hazards and applies stall, bubble, flush and memory-freeze actions.
- Sits between the opcode control decoder (producer) and the execute, memory and writeback datapaths (consumers).
- Owns the sticky halted and error indications for the core.

---
 rtl/ctrl_pipe_pkg.sv | 24 ++
 rtl/ctrl_stage_reg.sv | 22 ++
 rtl/ctrl_pipe.sv | 128 ++++++++++++
 tb/tb_ctrl_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the control pipeline: the per-stage control bundle and its bubble value.
// Bundle layout, MSB to LSB: valid, regWrite, memRead, memWrite, memToReg, branch, jump, halt, err, wrReg.
package ctrl_pipe_pkg;

    localparam int REG_W = 3;

    typedef struct packed {
        logic             valid;
        logic             regWrite;
        logic             memRead;
        logic             memWrite;
        logic             memToReg;
        logic             branch;
        logic             jump;
        logic             halt;
        logic             err;
        logic [REG_W-1:0] wrReg;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    localparam bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register for the control bundle.
// Precedence: rst clears it, otherwise en advances it, loading a bubble when clr is set.
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic [BUNDLE_W-1:0] d,
    output logic [BUNDLE_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= clr ? BUBBLE : d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control from ID through the EX/MEM/WB registers, with load-use
// stalls, flush bubbles, a memory freeze, and sticky halted/error flags.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_memWrite,
    input  logic             id_memToReg,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_halt,
    input  logic             id_err,
    input  logic [REG_W-1:0] id_wrReg,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_useRs,
    input  logic             id_useRt,
    input  logic             flush,
    input  logic             memStall,
    output logic             stallID,
    output logic             ex_valid,
    output logic             ex_regWrite,
    output logic             ex_memRead,
    output logic             ex_memWrite,
    output logic             ex_memToReg,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [REG_W-1:0] ex_wrReg,
    output logic             mem_valid,
    output logic             mem_regWrite,
    output logic             mem_memRead,
    output logic             mem_memWrite,
    output logic             mem_memToReg,
    output logic [REG_W-1:0] mem_wrReg,
    output logic             wb_valid,
    output logic             wb_regWrite,
    output logic             wb_memToReg,
    output logic [REG_W-1:0] wb_wrReg,
    output logic             halted,
    output logic             errOut
);

    bundle_t id_b, ex_q, mem_q, wb_q;
    logic    load_use, advance, ex_clr;
    logic    halted_q, err_q;
    logic    unused_bits;

    always_comb begin
        id_b          = BUBBLE;
        id_b.valid    = id_valid;
        id_b.regWrite = id_regWrite;
        id_b.memRead  = id_memRead;
        id_b.memWrite = id_memWrite;
        id_b.memToReg = id_memToReg;
        id_b.branch   = id_branch;
        id_b.jump     = id_jump;
        id_b.halt     = id_halt;
        id_b.err      = id_err;
        id_b.wrReg    = id_wrReg;
    end

    // A load in EX whose destination is read by the ID instruction; r0 is not special.
    always_comb begin
        load_use = ex_q.valid & ex_q.memRead & ex_q.regWrite & id_valid &
                   ((id_useRs & (id_rs == ex_q.wrReg)) |
                    (id_useRt & (id_rt == ex_q.wrReg)));
    end

    // memStall freezes every stage; otherwise EX takes a bubble on flush, hazard or halt.
    assign advance = ~memStall;
    assign ex_clr  = flush | load_use | halted_q;
    assign stallID = ~rst & (memStall | halted_q | (load_use & ~flush));

    ctrl_stage_reg u_ex (
        .clk (clk), .rst (rst), .en (advance), .clr (ex_clr), .d (id_b), .q (ex_q)
    );

    ctrl_stage_reg u_mem (
        .clk (clk), .rst (rst), .en (advance), .clr (1'b0), .d (ex_q), .q (mem_q)
    );

    ctrl_stage_reg u_wb (
        .clk (clk), .rst (rst), .en (advance), .clr (1'b0), .d (mem_q), .q (wb_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (wb_q.valid & wb_q.halt) halted_q <= 1'b1;
            if (wb_q.valid & wb_q.err)  err_q    <= 1'b1;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_regWrite  = ex_q.valid & ex_q.regWrite;
    assign ex_memRead   = ex_q.valid & ex_q.memRead;
    assign ex_memWrite  = ex_q.valid & ex_q.memWrite;
    assign ex_memToReg  = ex_q.memToReg;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_wrReg     = ex_q.wrReg;

    assign mem_valid    = mem_q.valid;
    assign mem_regWrite = mem_q.valid & mem_q.regWrite;
    assign mem_memRead  = mem_q.valid & mem_q.memRead;
    assign mem_memWrite = mem_q.valid & mem_q.memWrite;
    assign mem_memToReg = mem_q.memToReg;
    assign mem_wrReg    = mem_q.wrReg;

    assign wb_valid     = wb_q.valid;
    assign wb_regWrite  = wb_q.valid & wb_q.regWrite;
    assign wb_memToReg  = wb_q.memToReg;
    assign wb_wrReg     = wb_q.wrReg;

    assign halted = halted_q;
    assign errOut = err_q;

    // Branch/jump/memory bits are not consumed after the stage that needs them.
    assign unused_bits = ^{mem_q.branch, mem_q.jump, wb_q.memRead, wb_q.memWrite,
                           wb_q.branch, wb_q.jump};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a per-cycle reference model feeds an expected-output queue,
// and each scenario task adds its own hand-derived checks.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam int OBS_W = 26;

    logic       clk = 1'b0;
    logic       rst;
    bundle_t    idb;
    logic [2:0] id_rs, id_rt;
    logic       id_useRs, id_useRt, flush, memStall;

    logic       stallID;
    logic       ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_branch, ex_jump;
    logic [2:0] ex_wrReg;
    logic       mem_valid, mem_regWrite, mem_memRead, mem_memWrite, mem_memToReg;
    logic [2:0] mem_wrReg;
    logic       wb_valid, wb_regWrite, wb_memToReg;
    logic [2:0] wb_wrReg;
    logic       halted, errOut;

    bundle_t    m_ex, m_mem, m_wb;
    logic       m_halted, m_err;
    logic [OBS_W-1:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk (clk), .rst (rst),
        .id_valid (idb.valid), .id_regWrite (idb.regWrite), .id_memRead (idb.memRead),
        .id_memWrite (idb.memWrite), .id_memToReg (idb.memToReg), .id_branch (idb.branch),
        .id_jump (idb.jump), .id_halt (idb.halt), .id_err (idb.err), .id_wrReg (idb.wrReg),
        .id_rs (id_rs), .id_rt (id_rt), .id_useRs (id_useRs), .id_useRt (id_useRt),
        .flush (flush), .memStall (memStall), .stallID (stallID),
        .ex_valid (ex_valid), .ex_regWrite (ex_regWrite), .ex_memRead (ex_memRead),
        .ex_memWrite (ex_memWrite), .ex_memToReg (ex_memToReg), .ex_branch (ex_branch),
        .ex_jump (ex_jump), .ex_wrReg (ex_wrReg),
        .mem_valid (mem_valid), .mem_regWrite (mem_regWrite), .mem_memRead (mem_memRead),
        .mem_memWrite (mem_memWrite), .mem_memToReg (mem_memToReg), .mem_wrReg (mem_wrReg),
        .wb_valid (wb_valid), .wb_regWrite (wb_regWrite), .wb_memToReg (wb_memToReg),
        .wb_wrReg (wb_wrReg), .halted (halted), .errOut (errOut)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic m_load_use();
        return m_ex.valid && m_ex.memRead && m_ex.regWrite && idb.valid &&
               ((id_useRs && id_rs == m_ex.wrReg) || (id_useRt && id_rt == m_ex.wrReg));
    endfunction

    function automatic logic [OBS_W-1:0] pack_exp();
        return {m_ex.valid, m_ex.valid & m_ex.regWrite, m_ex.valid & m_ex.memRead,
                m_ex.valid & m_ex.memWrite, m_ex.memToReg, m_ex.branch, m_ex.jump, m_ex.wrReg,
                m_mem.valid, m_mem.valid & m_mem.regWrite, m_mem.valid & m_mem.memRead,
                m_mem.valid & m_mem.memWrite, m_mem.memToReg, m_mem.wrReg,
                m_wb.valid, m_wb.valid & m_wb.regWrite, m_wb.memToReg, m_wb.wrReg,
                m_halted, m_err};
    endfunction

    function automatic logic [OBS_W-1:0] pack_dut();
        return {ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_branch, ex_jump,
                ex_wrReg, mem_valid, mem_regWrite, mem_memRead, mem_memWrite, mem_memToReg,
                mem_wrReg, wb_valid, wb_regWrite, wb_memToReg, wb_wrReg, halted, errOut};
    endfunction

    task automatic model_step();
        logic kill;
        kill = flush || m_load_use() || m_halted;
        if (rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_halted = 1'b0; m_err = 1'b0;
        end else begin
            if (m_wb.valid && m_wb.halt) m_halted = 1'b1;
            if (m_wb.valid && m_wb.err)  m_err    = 1'b1;
            if (!memStall) begin
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = kill ? bundle_t'('0) : idb;
            end
        end
    endtask

    // One clock: check stallID against the model, clock, queue the model's view, compare.
    task automatic tick();
        logic exp_stall;
        logic [OBS_W-1:0] e, a;
        #1;
        exp_stall = !rst && (memStall || m_halted || (m_load_use() && !flush));
        n_cmp++;
        if (stallID !== exp_stall) begin
            n_err++;
            $display("FAIL stall_model t=%0t actual=%b required=%b", $time, stallID, exp_stall);
        end
        @(posedge clk);
        model_step();
        exp_q.push_back(pack_exp());
        @(negedge clk);
        e = exp_q.pop_front();
        a = pack_dut();
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL stage_outputs t=%0t actual=%b required=%b", $time, a, e);
        end
    endtask

    task automatic set_id(input logic v, rw, mr, mw, m2r, br, jp, hl, er,
                          input logic [2:0] wr, rs, rt, input logic urs, urt);
        idb.valid = v;  idb.regWrite = rw; idb.memRead = mr; idb.memWrite = mw;
        idb.memToReg = m2r; idb.branch = br; idb.jump = jp; idb.halt = hl; idb.err = er;
        idb.wrReg = wr; id_rs = rs; id_rt = rt; id_useRs = urs; id_useRt = urt;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; memStall = 1'b1; flush = 1'b0;
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd0, 3'd0, 0, 0);
        tick();
        tick();
        n_cmp++;
        if ({ex_valid, mem_valid, wb_valid, halted, errOut} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_clear actual=%b required=00000",
                     {ex_valid, mem_valid, wb_valid, halted, errOut});
        end
        #1;
        n_cmp++;
        if (stallID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall actual=%b required=0", stallID);
        end
        memStall = 1'b0;
    endtask

    task automatic test_flow();
        rst = 1'b0;
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd0, 3'd0, 0, 0);
        tick();
        idle();
        n_cmp++;
        if ({ex_valid, ex_regWrite, ex_wrReg} !== 5'b11_011) begin
            n_err++;
            $display("FAIL flow_ex actual=%b required=11011", {ex_valid, ex_regWrite, ex_wrReg});
        end
        tick();
        n_cmp++;
        if ({mem_valid, mem_regWrite, mem_wrReg} !== 5'b11_011) begin
            n_err++;
            $display("FAIL flow_mem actual=%b required=11011", {mem_valid, mem_regWrite, mem_wrReg});
        end
        tick();
        n_cmp++;
        if ({wb_valid, wb_regWrite, wb_wrReg} !== 5'b11_011) begin
            n_err++;
            $display("FAIL flow_wb actual=%b required=11011", {wb_valid, wb_regWrite, wb_wrReg});
        end
        tick();
    endtask

    task automatic test_load_use();
        set_id(1, 1, 1, 0, 1, 0, 0, 0, 0, 3'd2, 3'd0, 3'd0, 0, 0);
        tick();
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd4, 3'd2, 3'd0, 1, 0);
        #1;
        n_cmp++;
        if (stallID !== 1'b1) begin
            n_err++;
            $display("FAIL lu_stall actual=%b required=1", stallID);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lu_bubble actual=%b required=0", ex_valid);
        end
        #1;
        n_cmp++;
        if (stallID !== 1'b0) begin
            n_err++;
            $display("FAIL lu_one_cycle actual=%b required=0", stallID);
        end
        tick();
        n_cmp++;
        if ({ex_valid, ex_wrReg} !== 4'b1_100) begin
            n_err++;
            $display("FAIL lu_add_enters actual=%b required=1100", {ex_valid, ex_wrReg});
        end
        // Same registers but rs not read: no hazard.
        set_id(1, 1, 1, 0, 1, 0, 0, 0, 0, 3'd2, 3'd0, 3'd0, 0, 0);
        tick();
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd4, 3'd2, 3'd2, 0, 0);
        #1;
        n_cmp++;
        if (stallID !== 1'b0) begin
            n_err++;
            $display("FAIL lu_unused_rs actual=%b required=0", stallID);
        end
        tick();
        // Hazard via rt, including register 0.
        set_id(1, 1, 1, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        tick();
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd5, 3'd1, 3'd0, 0, 1);
        tick();
        tick();
        idle();
        tick();
    endtask

    task automatic test_flush();
        set_id(1, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd1, 3'd2, 1, 1);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 3'd1, 3'd2, 1, 1);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (stallID !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall actual=%b required=0", stallID);
        end
        tick();
        flush = 1'b0;
        idle();
        n_cmp++;
        if ({ex_valid, mem_valid, mem_memWrite} !== 3'b010) begin
            n_err++;
            $display("FAIL flush_kill actual=%b required=010", {ex_valid, mem_valid, mem_memWrite});
        end
        tick();
        n_cmp++;
        if ({mem_memWrite, wb_valid} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_st_gone actual=%b required=01", {mem_memWrite, wb_valid});
        end
        tick();
    endtask

    task automatic test_mem_stall();
        for (int i = 0; i < 10; i++) begin
            set_id(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0,
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            memStall = (i >= 3 && i < 6);
            if (memStall) begin
                #1;
                n_cmp++;
                if (stallID !== 1'b1) begin
                    n_err++;
                    $display("FAIL memstall_stall i=%0d actual=%b required=1", i, stallID);
                end
            end
            tick();
        end
        memStall = 1'b0;
        idle();
        repeat (3) tick();
    endtask

    task automatic test_priority();
        set_id(1, 1, 1, 0, 1, 0, 0, 0, 0, 3'd5, 3'd0, 3'd0, 0, 0);
        tick();
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd6, 3'd5, 3'd0, 1, 0);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (stallID !== 1'b0) begin
            n_err++;
            $display("FAIL prio_flush_lu_stall actual=%b required=0", stallID);
        end
        tick();
        flush = 1'b0;
        idle();
        n_cmp++;
        if (ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL prio_flush_lu_bubble actual=%b required=0", ex_valid);
        end
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd6, 3'd0, 3'd0, 0, 0);
        tick();
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd7, 3'd0, 3'd0, 0, 0);
        memStall = 1'b1;
        flush = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({ex_valid, ex_wrReg, stallID} !== 5'b1_110_1) begin
            n_err++;
            $display("FAIL prio_stall_freeze actual=%b required=11101", {ex_valid, ex_wrReg, stallID});
        end
        memStall = 1'b0;
        tick();
        n_cmp++;
        if ({ex_valid, mem_valid, mem_wrReg} !== 5'b0_1_110) begin
            n_err++;
            $display("FAIL prio_flush_after_stall actual=%b required=01110",
                     {ex_valid, mem_valid, mem_wrReg});
        end
        flush = 1'b0;
        idle();
        repeat (3) tick();
    endtask

    task automatic test_halt();
        set_id(1, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        repeat (4) tick();
        n_cmp++;
        if (halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_flushed actual=%b required=0", halted);
        end
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 3'd0, 3'd0, 0, 0);
        tick();
        idle();
        tick();
        tick();
        n_cmp++;
        if ({wb_valid, errOut} !== 2'b10) begin
            n_err++;
            $display("FAIL err_in_wb actual=%b required=10", {wb_valid, errOut});
        end
        tick();
        n_cmp++;
        if (errOut !== 1'b1) begin
            n_err++;
            $display("FAIL err_set actual=%b required=1", errOut);
        end
        set_id(1, 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        tick();
        idle();
        tick();
        tick();
        n_cmp++;
        if ({wb_valid, halted} !== 2'b10) begin
            n_err++;
            $display("FAIL halt_in_wb actual=%b required=10", {wb_valid, halted});
        end
        tick();
        n_cmp++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_set actual=%b required=1", halted);
        end
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'd0, 3'd0, 0, 0);
        #1;
        n_cmp++;
        if (stallID !== 1'b1) begin
            n_err++;
            $display("FAIL halt_stall actual=%b required=1", stallID);
        end
        tick();
        tick();
        n_cmp++;
        if ({ex_valid, halted, errOut} !== 3'b011) begin
            n_err++;
            $display("FAIL halt_drain actual=%b required=011", {ex_valid, halted, errOut});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_cmp++;
        if ({halted, errOut} !== 2'b00) begin
            n_err++;
            $display("FAIL sticky_reset actual=%b required=00", {halted, errOut});
        end
        tick();
    endtask

    initial begin
        m_ex = '0; m_mem = '0; m_wb = '0; m_halted = 1'b0; m_err = 1'b0;
        rst = 1'b1; flush = 1'b0; memStall = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_flow();
        test_load_use();
        test_flush();
        test_mem_stall();
        test_priority();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
